// File: rtl/lm75_i2c_master_if.sv
// Host-side request/response bundle for the LM75 I2C master.
// The "master" modport is the system controller; "slave" is the I2C engine it commands.
interface lm75_i2c_master_if;
    logic        Go;
    logic        R_W;
    logic [1:0]  Pointer;
    logic [1:0]  N_bytes;
    logic [15:0] Wr_data;
    logic [15:0] Rd_data;
    logic        Busy;
    logic        Done;
    logic        Ack_err;

    modport master (
        output Go, R_W, Pointer, N_bytes, Wr_data,
        input  Rd_data, Busy, Done, Ack_err
    );

    modport slave (
        input  Go, R_W, Pointer, N_bytes, Wr_data,
        output Rd_data, Busy, Done, Ack_err
    );
endinterface

// File: rtl/lm75_i2c_master.sv
// I2C master for the LM75 sensor: one pointer write (0-2 data bytes) or 1-2 byte read per Go.
// Each bit is four divider ticks; SCL and the SDA pull-down are registered so the pins never glitch.
module lm75_i2c_master #(
    parameter int         CLK_DIV  = 250,
    parameter logic [6:0] DEV_ADDR = 7'b1001000
) (
    input  logic               Clk,
    input  logic               Rst,
    lm75_i2c_master_if.slave   host,
    output logic               Scl,
    inout  wire                Sda
);

    localparam int DIV_W = $clog2(CLK_DIV);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ACK_A, PTR, ACK_P, WDATA, ACK_W, RDATA, MACK, STOP
    } state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         qtr;
    logic [2:0]         bit_cnt;
    logic               byte_idx;
    logic               tick, bit_end, sample, accept, last_byte;

    logic               r_w_l;
    logic [1:0]         ptr_l;
    logic [1:0]         n_l;
    logic [15:0]        wr_l;
    logic [7:0]         tx_sr, rx_sr, rx_hi;
    logic               sda_meta, sda_sync, sda_smp;

    logic               scl_c, sda_low_c, bit_scl;
    logic               scl_r, sda_low_r;
    logic               busy_r, done_r, ack_err_r;
    logic [15:0]        rd_data_r;

    assign tick      = (state != IDLE) && (div_cnt == DIV_W'(CLK_DIV - 1));
    assign bit_end   = tick && (qtr == 2'd3);
    assign sample    = tick && (qtr == 2'd1);
    assign accept    = (state == IDLE) && host.Go;
    assign last_byte = !n_l[1] || byte_idx;
    assign bit_scl   = (qtr == 2'd1) || (qtr == 2'd2);

    assign Scl          = scl_r;
    assign Sda          = sda_low_r ? 1'b0 : 1'bz;
    assign host.Busy    = busy_r;
    assign host.Done    = done_r;
    assign host.Ack_err = ack_err_r;
    assign host.Rd_data = rd_data_r;

    always_comb begin
        state_nxt = state;
        scl_c     = 1'b1;
        sda_low_c = 1'b0;
        case (state)
            IDLE: begin
                if (host.Go) state_nxt = START;
            end
            START: begin
                scl_c     = (qtr != 2'd3);
                sda_low_c = qtr[1];
                if (bit_end) state_nxt = ADDR;
            end
            ADDR: begin
                scl_c     = bit_scl;
                sda_low_c = ~tx_sr[7];
                if (bit_end && bit_cnt == 3'd7) state_nxt = ACK_A;
            end
            ACK_A: begin
                scl_c = bit_scl;
                if (bit_end) begin
                    if (sda_smp)    state_nxt = STOP;
                    else if (r_w_l) state_nxt = RDATA;
                    else            state_nxt = PTR;
                end
            end
            PTR: begin
                scl_c     = bit_scl;
                sda_low_c = ~tx_sr[7];
                if (bit_end && bit_cnt == 3'd7) state_nxt = ACK_P;
            end
            ACK_P: begin
                scl_c = bit_scl;
                if (bit_end) state_nxt = (sda_smp || n_l == 2'd0) ? STOP : WDATA;
            end
            WDATA: begin
                scl_c     = bit_scl;
                sda_low_c = ~tx_sr[7];
                if (bit_end && bit_cnt == 3'd7) state_nxt = ACK_W;
            end
            ACK_W: begin
                scl_c = bit_scl;
                if (bit_end) state_nxt = (sda_smp || last_byte) ? STOP : WDATA;
            end
            RDATA: begin
                scl_c = bit_scl;
                if (bit_end && bit_cnt == 3'd7) state_nxt = MACK;
            end
            MACK: begin
                // ACK every byte but the last, which gets a NACK so the slave lets go of SDA
                scl_c     = bit_scl;
                sda_low_c = ~last_byte;
                if (bit_end) state_nxt = last_byte ? STOP : RDATA;
            end
            STOP: begin
                scl_c     = (qtr != 2'd0);
                sda_low_c = ~qtr[1];
                if (bit_end) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state     <= IDLE;
            div_cnt   <= '0;
            qtr       <= 2'd0;
            bit_cnt   <= 3'd0;
            byte_idx  <= 1'b0;
            scl_r     <= 1'b1;
            sda_low_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            ack_err_r <= 1'b0;
            rd_data_r <= 16'h0000;
        end else begin
            state     <= state_nxt;
            scl_r     <= scl_c;
            sda_low_r <= sda_low_c;
            done_r    <= 1'b0;

            if (state == IDLE || tick) div_cnt <= '0;
            else                       div_cnt <= div_cnt + DIV_W'(1);

            if (tick) qtr <= qtr + 2'd1;

            if (bit_end) bit_cnt <= (state_nxt == state) ? bit_cnt + 3'd1 : 3'd0;

            if (accept) begin
                busy_r    <= 1'b1;
                ack_err_r <= 1'b0;
                byte_idx  <= 1'b0;
            end

            if (bit_end && ((state == ACK_W && state_nxt == WDATA) ||
                            (state == MACK  && state_nxt == RDATA)))
                byte_idx <= 1'b1;

            if (bit_end && sda_smp && (state == ACK_A || state == ACK_P || state == ACK_W))
                ack_err_r <= 1'b1;

            // Read data is only published for a read that completed without a NACK
            if (bit_end && state == STOP) begin
                busy_r <= 1'b0;
                done_r <= 1'b1;
                if (r_w_l && !ack_err_r)
                    rd_data_r <= n_l[1] ? {rx_hi, rx_sr} : {8'h00, rx_sr};
            end
        end
    end

    always_ff @(posedge Clk) begin
        sda_meta <= Sda;
        sda_sync <= sda_meta;

        if (accept) begin
            r_w_l <= host.R_W;
            ptr_l <= host.Pointer;
            n_l   <= host.N_bytes;
            wr_l  <= host.Wr_data;
        end

        if (bit_end) begin
            if (state == START)
                tx_sr <= {DEV_ADDR, r_w_l};
            else if (state_nxt == PTR && state != PTR)
                tx_sr <= {6'b000000, ptr_l};
            else if (state_nxt == WDATA && state != WDATA)
                tx_sr <= (state == ACK_P && n_l[1]) ? wr_l[15:8] : wr_l[7:0];
            else
                tx_sr <= {tx_sr[6:0], 1'b0};

            if (state == MACK && state_nxt == RDATA) rx_hi <= rx_sr;
        end

        if (sample) sda_smp <= sda_sync;
        if (sample && state == RDATA) rx_sr <= {rx_sr[6:0], sda_sync};
    end

endmodule
